// File: rtl/lab62_debounce_pkg.sv
// ============================================================================
// Module   : lab62_debounce_pkg
// Brief    : Shared state encodings, output bundle and sizing helper for the
//            per-channel button debouncer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lab62_debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_stable0 = 2'd0;
    localparam state_t c_check1  = 2'd1;
    localparam state_t c_stable1 = 2'd2;
    localparam state_t c_check0  = 2'd3;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } cell_out_t;

    // Smallest width able to hold value-1; never below one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lab62_debounce_cell.sv
// ============================================================================
// Module   : lab62_debounce_cell
// Brief    : One button channel: 2-flop synchronizer, four-state debounce FSM
//            and stability counter with registered level/press/release outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lab62_debounce_cell
    import lab62_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CNT_W       = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic           c_released  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_sample;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    cell_out_t        r_out;
    cell_out_t        w_out_nxt;

    // Synchronizer parks at the released pad level so reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= c_released;
            r_sync2 <= c_released;
        end else begin
            r_sync1 <= pad;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_stable0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_stable0: begin
                if (w_sample) begin
                    w_state_nxt = c_check1;
                    w_cnt_nxt   = '0;
                end
            end
            c_check1: begin
                if (!w_sample) begin
                    w_state_nxt = c_stable0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_stable1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_stable1: begin
                if (!w_sample) begin
                    w_state_nxt = c_check0;
                    w_cnt_nxt   = '0;
                end
            end
            c_check0: begin
                if (w_sample) begin
                    w_state_nxt = c_stable1;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_stable0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_stable0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they register on the same edge.
    always_comb begin
        w_out_nxt       = '0;
        w_out_nxt.level = (w_state_nxt == c_stable1) || (w_state_nxt == c_check0);
        w_out_nxt.rise  = (r_state == c_check1) && (w_state_nxt == c_stable1);
        w_out_nxt.fall  = (r_state == c_check0) && (w_state_nxt == c_stable0);
    end

    assign level = r_out.level;
    assign rise  = r_out.rise;
    assign fall  = r_out.fall;

endmodule

`default_nettype wire

// File: rtl/lab62_button_debounce.sv
// ============================================================================
// Module   : lab62_button_debounce
// Brief    : WIDTH independent debounced button channels with press/release
//            strobes and a registered pressed level for the PIO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lab62_button_debounce
    import lab62_debounce_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_pad,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cell
            lab62_debounce_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_cell (
                .clk     (clk),
                .reset_n (reset_n),
                .pad     (btn_pad[g]),
                .level   (level_out[g]),
                .rise    (rise_pulse[g]),
                .fall    (fall_pulse[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_lab62_button_debounce.sv
// ============================================================================
// Module   : tb_lab62_button_debounce
// Brief    : Scoreboard bench for the button debouncer against a run-length
//            reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lab62_button_debounce;

    localparam int WIDTH = 2;
    localparam int N     = 4;
    localparam int ALOW  = 1;

    typedef struct packed {
        logic [WIDTH-1:0] level;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] btn_pad;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;

    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;
    int   edge_no;

    // Reference model: pad samples reach the decision two edges late; the level
    // flips once N+1 consecutive decision samples disagree with it.
    int   m_run  [WIDTH];
    logic m_level[WIDTH];
    logic m_d1   [WIDTH];
    logic m_d2   [WIDTH];

    lab62_button_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (N),
        .ACTIVE_LOW      (ALOW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_pad    (btn_pad),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < WIDTH; c++) begin
            m_run[c]   = 0;
            m_level[c] = 1'b0;
            m_d1[c]    = 1'b1;
            m_d2[c]    = 1'b1;
        end
    endtask

    // Predict the outputs after the next rising edge, given pad/reset held there.
    task automatic step(input logic [WIDTH-1:0] pad, input logic rn);
        exp_t e;
        logic pressed;
        @(negedge clk);
        btn_pad = pad;
        reset_n = rn;
        e = '0;
        if (!rn) begin
            model_reset();
        end else begin
            for (int c = 0; c < WIDTH; c++) begin
                pressed = (m_d2[c] == 1'b0);
                if (pressed != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == N + 1) begin
                        m_level[c] = pressed;
                        m_run[c]   = 0;
                        e.rise[c]  = pressed;
                        e.fall[c]  = !pressed;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_d2[c] = m_d1[c];
                m_d1[c] = pad[c];
            end
        end
        for (int c = 0; c < WIDTH; c++) e.level[c] = m_level[c];
        sb_q.push_back(e);
    endtask

    task automatic hold(input logic [WIDTH-1:0] pad, input int cycles);
        for (int i = 0; i < cycles; i++) step(pad, 1'b1);
    endtask

    // Monitor: the DUT presents its three outputs every cycle.
    initial begin
        exp_t e;
        edge_no = 0;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (level_out === e.level) n_pass++;
                else $display("FAIL level_out edge %0d: got %b expected %b", edge_no, level_out, e.level);
                n_checks++;
                if (rise_pulse === e.rise) n_pass++;
                else $display("FAIL rise_pulse edge %0d: got %b expected %b", edge_no, rise_pulse, e.rise);
                n_checks++;
                if (fall_pulse === e.fall) n_pass++;
                else $display("FAIL fall_pulse edge %0d: got %b expected %b", edge_no, fall_pulse, e.fall);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        reset_n = 1'b0;
        btn_pad = 2'b11;

        for (int i = 0; i < 3; i++) step(2'b11, 1'b0);
        hold(2'b11, 4);

        // Clean press and release on channel 0.
        hold(2'b10, 10);
        hold(2'b11, 10);

        // Bounce during the press check.
        hold(2'b10, 3);
        hold(2'b11, 1);
        hold(2'b10, 10);
        hold(2'b11, 10);

        // Reset pulsed while a check is in progress, pad still pressed afterwards.
        hold(2'b10, 4);
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        hold(2'b10, 10);
        hold(2'b11, 10);

        // Both channels together, then staggered by two cycles.
        hold(2'b00, 10);
        hold(2'b11, 10);
        hold(2'b10, 2);
        hold(2'b00, 10);
        hold(2'b01, 2);
        hold(2'b11, 10);

        // Single-cycle glitch while released.
        hold(2'b10, 1);
        hold(2'b11, 8);

        // Randomized pad activity, including occasional resets.
        for (int s = 0; s < 60; s++) begin
            logic [WIDTH-1:0] p;
            p = WIDTH'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) begin
                step(p, 1'b0);
            end
            hold(p, $urandom_range(1, 9));
        end
        hold(2'b11, 10);

        @(posedge clk);
        #3;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lab62_button_debounce.md
LAB62_BUTTON_DEBOUNCE -- requirements
Module: lab62_button_debounce

Interface
REQ-001 Parameter WIDTH, default 2: number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): required stable cycles; legal minimum 2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means a pad reads 0 when the button is pressed.
REQ-004 Port clk  input  1: single system clock; all state SHALL be clocked on its rising edge.
REQ-005 Port reset_n  input  1: asynchronous, active-low reset.
REQ-006 Port btn_pad  input  WIDTH: raw, asynchronous, bouncing button pads.
REQ-007 Port level_out  output  WIDTH: debounced pressed level (1 = pressed); drives the PIO in_port downstream.
REQ-008 Port rise_pulse  output  WIDTH: one-cycle strobe on a debounced press.
REQ-009 Port fall_pulse  output  WIDTH: one-cycle strobe on a debounced release.

Function
REQ-010 Each channel SHALL pass btn_pad through a 2-flop synchronizer before any other logic uses it.
REQ-011 Normalized sample r SHALL equal the inverted synchronizer output when ACTIVE_LOW=1, otherwise the synchronizer output unchanged.
REQ-012 Each channel SHALL run its own FSM with states STABLE0, CHECK1, STABLE1 and CHECK0, plus a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-013 STABLE0 with r=1 SHALL go to CHECK1 and clear the counter to 0; with r=0 it SHALL hold.
REQ-014 CHECK1 with r=0 SHALL return to STABLE0 and emit no pulse.
REQ-015 CHECK1 with r=1 and counter below DEBOUNCE_CYCLES-1 SHALL increment the counter.
REQ-016 CHECK1 with r=1 and counter = DEBOUNCE_CYCLES-1 SHALL go to STABLE1.
REQ-017 STABLE1 and CHECK0 SHALL mirror REQ-013 to REQ-016 with r inverted; CHECK0 completes into STABLE0.
REQ-018 level_out SHALL be a registered output, 1 exactly in STABLE1 and CHECK0.
REQ-019 rise_pulse SHALL be registered high for exactly one cycle on the edge that enters STABLE1.
REQ-020 fall_pulse SHALL be registered high for exactly one cycle on the edge that enters STABLE0 from CHECK0.
REQ-021 Latency: a pad change held stable SHALL change level_out on the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples the new pad value as edge 1.
REQ-022 Any bounce during CHECK1 or CHECK0 SHALL abort the check; the full DEBOUNCE_CYCLES count SHALL restart on the next qualifying transition.
REQ-023 The counter SHALL never wrap, since it is cleared on entry to a CHECK state and stops at DEBOUNCE_CYCLES-1.
REQ-024 Channels SHALL be fully independent; simultaneous activity on several channels SHALL produce independent, possibly simultaneous, pulses.
REQ-025 rise_pulse and fall_pulse on the same channel SHALL never be high in the same cycle.

Reset
REQ-026 While reset_n=0, every channel SHALL be in STABLE0 with its counter at 0.
REQ-027 While reset_n=0, level_out, rise_pulse and fall_pulse SHALL all be 0.
REQ-028 While reset_n=0, the synchronizer flops SHALL hold the released pad value: 1 when ACTIVE_LOW=1, else 0.
REQ-029 Reset asserted mid-check SHALL abandon the check without emitting a pulse.
REQ-030 A button held pressed through reset release SHALL be debounced normally and produce one rise_pulse per REQ-021.

Structure
REQ-031 The FSM state encodings SHALL be defined in shared package lab62_debounce_pkg, along with a clog2 helper for the counter width.
REQ-032 The top SHALL instantiate WIDTH copies of one sub-module, lab62_debounce_cell; each cell contains one synchronizer, one FSM and one counter.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, WIDTH=2)
REQ-033 Clean press: pad0 1->0 and held -> level_out[0]=1 and rise_pulse[0]=1 for one cycle at edge 7.
REQ-034 Bounce: pad0 low for 3 cycles, high for 1 cycle, then low and held -> no pulse from the first attempt; rise_pulse at edge 7 counted from the final 1->0 sample.
REQ-035 Release: pad0 0->1 and held after a debounced press -> fall_pulse[0] at edge 7 and level_out[0]=0 at edge 7.
REQ-036 Reset mid-check: reset_n pulsed low in CHECK1 -> all outputs 0 with no pulse; pad still low after release -> rise_pulse 7 edges later.
REQ-037 Independent channels: both pads pressed on the same edge -> rise_pulse=2'b11 in a single cycle; staggering the pads by 2 cycles -> pulses staggered by 2 cycles.
REQ-038 Glitch: a one-cycle pad low while level_out=0 -> no output activity.
